// File: rtl/arb_rr_pkt.sv
// Round-robin packet arbiter: a grant is locked to one requester until ack&last
// or a no-ack timeout, then the pointer rotates past the grantee and re-arbitrates.
module arb_rr_pkt #(
  parameter int WID  = 4,
  parameter int TOUT = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WID-1:0]                         rqsts,
  input  logic                                   ack,
  input  logic                                   last,
  output logic [WID-1:0]                         grnts,
  output logic                                   gnt_vld,
  output logic [((WID > 1) ? $clog2(WID) : 1)-1:0] gnt_idx,
  output logic                                   tout
);
  localparam int IW = (WID > 1) ? $clog2(WID) : 1;
  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt, idx_nxt, arb_base;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           vld_nxt, tout_nxt;
  logic [WID-1:0] arb_req, grnts_nxt;

  // Arbitration: lowest request at or above base, else lowest overall.
  logic           hi_fnd, lo_fnd, win_fnd;
  logic [IW-1:0]  hi_idx, lo_idx, win_idx;

  always_comb begin
    hi_fnd = 1'b0;
    lo_fnd = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = WID - 1; i >= 0; i--) begin
      if (arb_req[i]) begin
        lo_fnd = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(arb_base)) begin
          hi_fnd = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    win_fnd = lo_fnd;
    win_idx = hi_fnd ? hi_idx : lo_idx;
  end

  logic rel;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    tout_nxt  = 1'b0;
    arb_base  = ptr;
    arb_req   = rqsts;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (win_fnd) begin
          state_nxt = BUSY;
          vld_nxt   = 1'b1;
          idx_nxt   = win_idx;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (ack && last) begin
          rel = 1'b1;
        end else if (ack) begin
          cnt_nxt = '0;
        end else if (cnt >= CW'(TOUT - 1)) begin
          rel      = 1'b1;
          tout_nxt = 1'b1;
        end else begin
          cnt_nxt = (cnt == CW'(TOUT)) ? cnt : cnt + 1'b1;
        end
        if (rel) begin
          // Grantee's own bit is excluded so it cannot immediately win again.
          ptr_nxt  = (gnt_idx == IW'(WID - 1)) ? '0 : gnt_idx + 1'b1;
          arb_base = ptr_nxt;
          arb_req  = rqsts & ~(WID'(1) << gnt_idx);
          cnt_nxt  = '0;
          if (win_fnd) begin
            idx_nxt = win_idx;
          end else begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            idx_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    grnts_nxt = vld_nxt ? (WID'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grnts   <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      tout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      grnts   <= grnts_nxt;
      gnt_vld <= vld_nxt;
      gnt_idx <= idx_nxt;
      tout    <= tout_nxt;
    end
  end
endmodule

// File: tb/tb_arb_rr_pkt.sv
// Directed scenarios plus random traffic for arb_rr_pkt, checked every cycle
// against a rotate-and-search packet arbiter model.
module tb_arb_rr_pkt;
  localparam int WID  = 4;
  localparam int TOUT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [WID-1:0] rqsts;
  logic           ack, last;
  logic [WID-1:0] grnts;
  logic           gnt_vld;
  logic [1:0]     gnt_idx;
  logic           tout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_busy;
  int m_g, m_ptr, m_cnt;
  bit m_tout;

  arb_rr_pkt #(.WID(WID), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .rqsts(rqsts), .ack(ack), .last(last),
    .grnts(grnts), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [WID-1:0] r, input int p);
    for (int k = 0; k < WID; k++)
      if (r[(p + k) % WID]) return (p + k) % WID;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_tout = 0;
  endtask

  task automatic model_step(input logic [WID-1:0] r, input logic a, input logic l);
    bit rel;
    int w;
    rel    = 0;
    m_tout = 0;
    if (!m_busy) begin
      if (r != 0) begin
        m_g = pick(r, m_ptr); m_busy = 1; m_cnt = 0;
      end
    end else begin
      if (a && l) rel = 1;
      else if (a) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt >= TOUT) begin rel = 1; m_tout = 1; end
      end
      if (rel) begin
        m_ptr = (m_g + 1) % WID;
        w = pick(r & ~(WID'(1) << m_g), m_ptr);
        if (w >= 0) begin m_g = w; m_cnt = 0; end
        else m_busy = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grnts"}, 32'(grnts),   m_busy ? 32'(1) << m_g : 32'd0);
    chk({tag, ".vld"},   32'(gnt_vld), 32'(m_busy));
    chk({tag, ".idx"},   32'(gnt_idx), m_busy ? 32'(m_g) : 32'd0);
    chk({tag, ".tout"},  32'(tout),    32'(m_tout));
  endtask

  // Called on a negedge; leaves the bench on the next negedge with outputs checked.
  task automatic step(input string tag, input logic [WID-1:0] r, input logic a, input logic l);
    rqsts = r; ack = a; last = l;
    @(posedge clk);
    model_step(r, a, l);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".async_grnts"}, 32'(grnts),   32'd0);
    chk({tag, ".async_vld"},   32'(gnt_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq_exp [5];
    rst = 1'b1; rqsts = '0; ack = 1'b0; last = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic grant and back-to-back handoff
    step("r029a", 4'b1010, 0, 0);
    chk("r029_g1", 32'(grnts), 32'b0010);
    chk("r029_i1", 32'(gnt_idx), 32'd1);
    step("r029b", 4'b1010, 1, 1);
    chk("r029_g3", 32'(grnts), 32'b1000);
    chk("r029_i3", 32'(gnt_idx), 32'd3);
    step("r029c", 4'b0000, 1, 1);

    // Fairness under full load
    seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
    seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
    step("r030a", 4'b1111, 0, 0);
    chk("r030_0", 32'(grnts), 32'(seq_exp[0]));
    for (int i = 1; i < 5; i++) begin
      step("r030b", 4'b1111, 1, 1);
      chk("r030_seq", 32'(grnts), 32'(seq_exp[i]));
    end
    step("r030c", 4'b0000, 1, 1);

    // Lock through non-last acks and request changes
    step("r031a", 4'b0100, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("r031b", 4'b0001, 1, 0);
      chk("r031_lock", 32'(grnts), 32'b0100);
    end
    step("r031c", 4'b0001, 1, 1);
    chk("r031_rel", 32'(grnts), 32'b0001);
    step("r031d", 4'b0000, 1, 1);

    // Timeout to idle
    step("r032a", 4'b0001, 0, 0);
    for (int i = 0; i < TOUT - 1; i++) step("r032b", 4'b0000, 0, 0);
    chk("r032_hold", 32'(grnts), 32'b0001);
    step("r032c", 4'b0000, 0, 0);
    chk("r032_tout", 32'(tout), 32'd1);
    chk("r032_idle", 32'(grnts), 32'd0);
    step("r032d", 4'b0000, 0, 0);
    chk("r032_pulse", 32'(tout), 32'd0);

    // Ack restarts the count; timeout then hands off to requester 1
    step("r032e", 4'b0001, 0, 0);
    for (int i = 0; i < TOUT - 2; i++) step("r032f", 4'b0011, 0, 0);
    step("r032g", 4'b0011, 1, 0);
    for (int i = 0; i < TOUT - 1; i++) step("r032h", 4'b0011, 0, 0);
    chk("r032_notout", 32'(tout), 32'd0);
    step("r032i", 4'b0011, 0, 0);
    chk("r032_tout2", 32'(tout), 32'd1);
    chk("r032_next", 32'(grnts), 32'b0010);
    step("r032j", 4'b0000, 1, 1);

    // Pointer wrap
    step("r033a", 4'b1000, 0, 0);
    chk("r033_g3", 32'(grnts), 32'b1000);
    step("r033b", 4'b1001, 1, 1);
    chk("r033_wrap", 32'(grnts), 32'b0001);
    step("r033c", 4'b0000, 1, 1);

    // Reset mid-packet
    step("r034a", 4'b1000, 0, 0);
    mid_reset("r034");
    step("r034b", 4'b1000, 0, 0);
    chk("r034_g", 32'(grnts), 32'b1000);
    chk("r034_tout", 32'(tout), 32'd0);

    // Random traffic, short timeout-prone ack stretches included
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic a, l;
      r = 4'($urandom);
      a = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 1) == 0);
      if (i % 100 == 99) mid_reset("rnd_rst");
      step("rnd", r, a, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_rr_pkt.md
ARB_RR_PKT -- requirements
Module: arb_rr_pkt

Interface
REQ-001 SHALL have parameter WID, default 4, number of requesters (WID >= 1).
REQ-002 SHALL have parameter TOUT, default 16, max cycles a grant may wait for ack before forced release (TOUT >= 1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rqsts  input  WID  request bus, bit i = requester i.
REQ-006 SHALL have port ack  input  1  consumer accepted one beat from current grantee.
REQ-007 SHALL have port last  input  1  qualifies ack; beat is last of packet.
REQ-008 SHALL have port grnts  output  WID  registered one-hot grant bus, zero when idle.
REQ-009 SHALL have port gnt_vld  output  1  registered; high iff grnts nonzero.
REQ-010 SHALL have port gnt_idx  output  max(1,clog2(WID))  registered binary index of grantee; 0 when idle.
REQ-011 SHALL have port tout  output  1  registered one-cycle pulse on forced release.

Function
REQ-012 SHALL implement two states: IDLE (no grant) and BUSY (grant locked to one requester).
REQ-013 SHALL hold a priority pointer ptr (0..WID-1); requester ptr has highest priority, then ptr+1, ... wrapping WID-1 -> 0.
REQ-014 SHALL pick winner = lowest set index of rqsts masked to indices >= ptr; if masked set empty, lowest set index of unmasked rqsts.
REQ-015 In IDLE with rqsts nonzero at edge n, SHALL assert grnts/gnt_vld/gnt_idx for winner from edge n (visible cycle n+1) and enter BUSY; latency 1 cycle.
REQ-016 In IDLE with rqsts zero, SHALL stay IDLE; ack/last ignored.
REQ-017 In BUSY, grant SHALL stay locked to grantee regardless of rqsts changes, including grantee deasserting its request.
REQ-018 In BUSY, ack without last SHALL keep grant and clear the timeout counter.
REQ-019 In BUSY, ack & last at an edge SHALL release: ptr <= (grantee+1) mod WID, and on same edge arbitrate rqsts with the new ptr (grantee's own bit excluded for this decision); winner found -> new grant next cycle with no idle bubble, stay BUSY; none -> go IDLE, outputs zero.
REQ-020 Timeout counter SHALL count BUSY cycles since grant or last ack; when it reaches TOUT with no ack, SHALL force release exactly as REQ-019 and pulse tout for one cycle.
REQ-021 ack & last coinciding with the timeout edge SHALL be treated as a normal release; tout stays low.
REQ-022 Counter SHALL saturate logic-wise at TOUT and reset to 0 on every new grant.
REQ-023 grnts SHALL never have more than one bit set; gnt_idx SHALL always encode the set bit.
REQ-024 WID=1 SHALL degrade to lock/release of single requester; ptr constant 0.
REQ-025 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-026 On rst high, asynchronously: state IDLE, grnts 0, gnt_vld 0, gnt_idx 0, tout 0, ptr 0, counter 0.
REQ-027 Reset asserted mid-packet SHALL drop grant immediately; after rst low, first arbitration uses ptr 0.
REQ-028 First arbitration SHALL occur at the first rising edge with rst low.

Verification (WID=4, TOUT=16)
REQ-029 After reset, rqsts=4'b1010 -> next cycle grnts=4'b0010, gnt_idx=1; ack&last -> next cycle grnts=4'b1000, gnt_idx=3 with no zero cycle.
REQ-030 Fairness: rqsts=4'b1111 held, ack&last every cycle -> grant sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 Lock: grant to 2, rqsts changes to 4'b0001 and ack (last=0) for 5 cycles -> grnts stays 4'b0100; ack&last -> grnts=4'b0001.
REQ-032 Timeout: grant to 0, no ack for 16 cycles -> tout pulses once, grant moves to next requester per ptr=1 or outputs zero if rqsts=0; ack at cycle 15 restarts count.
REQ-033 Wrap: grant to 3, rqsts=4'b1001, release -> grnts=4'b0001, ptr wraps to 0.
REQ-034 Reset mid-operation: rst pulsed during BUSY grant to 3 -> grnts=0 asynchronously; after release of rst with rqsts=4'b1000 -> grnts=4'b1000 one cycle later, tout never asserted.
